// File: rtl/uart_pkg.sv
// Shared definitions for the sensor-response UART path: FSM encoding,
// frame geometry and the response codes carried in the command byte.
package uart_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_START = 2'd1;
  localparam logic [1:0] ENC_DATA  = 2'd2;
  localparam logic [1:0] ENC_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_START = ENC_START,
    ST_DATA  = ENC_DATA,
    ST_STOP  = ENC_STOP
  } tx_state_t;

  localparam int DATA_BITS       = 8;
  localparam int BYTES_PER_FRAME = 2;

  localparam logic [7:0] RESP_OK             = 8'h07;
  localparam logic [7:0] RESP_SENSOR_FAULT   = 8'h1F;
  localparam logic [7:0] RESP_ERROR          = 8'h45;
  localparam logic [7:0] RESP_TEMP_SINGLE    = 8'h09;
  localparam logic [7:0] RESP_HUM_SINGLE     = 8'h08;
  localparam logic [7:0] RESP_TEMP_CONT      = 8'h0D;
  localparam logic [7:0] RESP_HUM_CONT       = 8'h0E;
  localparam logic [7:0] RESP_TEMP_CONT_STOP = 8'h0A;
  localparam logic [7:0] RESP_HUM_CONT_STOP  = 8'h0B;
  localparam logic [7:0] RESP_INVALID_A      = 8'hAA;
  localparam logic [7:0] RESP_INVALID_B      = 8'hFF;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A start presented during the last stop-bit
// cycle chains the next byte with no idle gap on the line.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      // done is raised one cycle early so it covers the final stop-bit cycle
      done <= (state == ST_STOP) && (cnt == CNT_PENULT);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= ST_START;
            tx    <= 1'b0;
            shreg <= data;
          end
        end
        ST_START: begin
          if (cnt == CNT_LAST) begin
            state   <= ST_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (start) begin
              state <= ST_START;
              tx    <= 1'b0;
              shreg <= data;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/envio_resposta_uart.sv
// Sends the sensor stage's command/value pair as two back-to-back 8N1 bytes,
// with rising-edge request detection and a one-deep pending buffer.
module envio_resposta_uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dados_validos,
  input  logic [7:0] response_command,
  input  logic [7:0] response_value,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("envio_resposta_uart: CLKS_PER_BIT must be at least 2");
  end

  logic       dv_prev;
  logic       request;
  logic       pend_full;
  logic [7:0] pend_cmd;
  logic [7:0] pend_val;
  logic [7:0] val_hold;
  logic       byte_sel;

  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_busy;
  logic       byte_done;
  logic       byte_tx;

  logic       take_req;
  logic       take_pend;
  logic       next_byte;
  logic       frame_end;
  logic       queue_req;
  logic       drop_req;

  assign request   = dados_validos & ~dv_prev;
  assign frame_end = byte_done & byte_sel;
  // In the final stop cycle a fresh request is launched directly instead of
  // passing through the pending slot; the line timing is identical.
  assign queue_req = request & byte_busy & ~pend_full & ~frame_end;
  assign drop_req  = request & byte_busy & pend_full;

  always_comb begin
    byte_start = 1'b0;
    byte_data  = response_command;
    take_req   = 1'b0;
    take_pend  = 1'b0;
    next_byte  = 1'b0;
    if (!byte_busy) begin
      if (request) begin
        byte_start = 1'b1;
        take_req   = 1'b1;
      end else if (pend_full) begin
        byte_start = 1'b1;
        byte_data  = pend_cmd;
        take_pend  = 1'b1;
      end
    end else if (byte_done) begin
      if (!byte_sel) begin
        byte_start = 1'b1;
        byte_data  = val_hold;
        next_byte  = 1'b1;
      end else if (pend_full) begin
        byte_start = 1'b1;
        byte_data  = pend_cmd;
        take_pend  = 1'b1;
      end else if (request) begin
        byte_start = 1'b1;
        take_req   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dv_prev   <= 1'b0;
      pend_full <= 1'b0;
      byte_sel  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dv_prev <= dados_validos;
      overrun <= drop_req;
      if (take_req || take_pend) begin
        byte_sel <= 1'b0;
      end else if (next_byte) begin
        byte_sel <= 1'b1;
      end
      if (take_pend) begin
        pend_full <= 1'b0;
      end else if (queue_req) begin
        pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (take_req) begin
      val_hold <= response_value;
    end else if (take_pend) begin
      val_hold <= pend_val;
    end
    if (queue_req) begin
      pend_cmd <= response_command;
      pend_val <= response_value;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock (clock),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .tx    (byte_tx),
    .busy  (byte_busy),
    .done  (byte_done)
  );

  assign tx   = byte_tx;
  assign busy = byte_busy;
  assign done = frame_end;

endmodule

// File: tb/tb_envio_resposta_uart.sv
// Bench for envio_resposta_uart: a line-level reference model predicts tx,
// busy, done and overrun every cycle from the requests it has seen.
module tb_envio_resposta_uart;
  import uart_pkg::*;

  localparam int CPB = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       dados_validos;
  logic [7:0] response_command;
  logic [7:0] response_value;
  logic       tx, busy, done, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic b;
    logic last;
  } samp_t;

  samp_t      q[$];
  logic       m_prev = 1'b0;
  logic       m_pend = 1'b0;
  logic [7:0] m_pc, m_pv;
  logic       m_ov = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  envio_resposta_uart #(
    .CLK_FREQ(100),
    .BAUD    (10)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dados_validos   (dados_validos),
    .response_command(response_command),
    .response_value  (response_value),
    .tx              (tx),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun)
  );

  // Expected line samples of one full two-byte frame, one entry per clock.
  function automatic void push_frame(input logic [7:0] c, input logic [7:0] v);
    logic [7:0] by;
    logic       bitv;
    for (int n = 0; n < 2; n++) begin
      by = (n == 0) ? c : v;
      for (int bi = 0; bi < 10; bi++) begin
        bitv = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : by[bi-1];
        for (int t = 0; t < CPB; t++)
          q.push_back(samp_t'{b: bitv, last: (n == 1 && bi == 9 && t == CPB - 1)});
      end
    end
  endfunction

  function automatic void model_edge(input logic dv, input logic [7:0] c,
                                     input logic [7:0] v, input logic rst);
    logic was_busy, req;
    if (rst) begin
      q.delete();
      m_pend = 1'b0;
      m_prev = 1'b0;
      m_ov   = 1'b0;
    end else begin
      was_busy = (q.size() > 0);
      if (was_busy) void'(q.pop_front());
      req    = dv && !m_prev;
      m_prev = dv;
      m_ov   = 1'b0;
      if (req) begin
        if (!was_busy) push_frame(c, v);
        else if (m_pend) m_ov = 1'b1;
        else begin
          m_pend = 1'b1;
          m_pc   = c;
          m_pv   = v;
        end
      end
      if (q.size() == 0 && m_pend) begin
        push_frame(m_pc, m_pv);
        m_pend = 1'b0;
      end
    end
  endfunction

  // {tx, busy, done, overrun}
  function automatic logic [3:0] model_out();
    if (q.size() == 0) return {1'b1, 1'b0, 1'b0, m_ov};
    return {q[0].b, 1'b1, q[0].last, m_ov};
  endfunction

  task automatic advance(input logic dv, input logic [7:0] c, input logic [7:0] v,
                         input logic rst);
    dados_validos    = dv;
    response_command = c;
    response_value   = v;
    reset            = rst;
    @(posedge clock);
    model_edge(dv, c, v, rst);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got, want;
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      got = {tx, busy, done, overrun};
      checks++;
      if (got !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, got, 4'b1000);
      end
    end
    for (int i = 0; i < 5; i++) begin
      advance(1'b0, 8'h00, 8'h00, 1'b0);
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] got, want;
    int done_at = -1;
    int fall_at = -1;
    advance(1'b1, RESP_TEMP_SINGLE, 8'h19, 1'b0);
    for (int i = 1; i <= 215; i++) begin
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_frame cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (done && done_at < 0) done_at = i;
      if (!busy && fall_at < 0) fall_at = i;
      advance(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    end
    checks++;
    if (done_at != 200) begin
      errors++;
      $display("FAIL basic_done_latency got=%0d want=200", done_at);
    end
    checks++;
    if (fall_at != 201) begin
      errors++;
      $display("FAIL basic_busy_fall got=%0d want=201", fall_at);
    end
  endtask

  task automatic test_held_level();
    logic [3:0] got, want;
    int n_done = 0;
    int n_ovr  = 0;
    for (int i = 0; i < 520; i++) begin
      advance(i < 500, RESP_TEMP_CONT, 8'h1A, 1'b0);
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL held_level cyc=%0d got=%b want=%b", cyc, got, want);
      end
      n_done += int'(done);
      n_ovr  += int'(overrun);
    end
    checks++;
    if (n_done != 1 || n_ovr != 0) begin
      errors++;
      $display("FAIL held_frames got done=%0d ovr=%0d want done=1 ovr=0", n_done, n_ovr);
    end
  endtask

  task automatic test_queueing();
    logic [3:0] got, want;
    logic       dv;
    logic [7:0] c, v;
    int n_busy = 0;
    int n_ovr  = 0;
    for (int i = 0; i < 420; i++) begin
      dv = (i == 0 || i == 45 || i == 55);
      c  = (i == 55) ? 8'($urandom) : RESP_HUM_CONT;
      v  = (i == 0) ? 8'h30 : (i == 45) ? 8'h31 : 8'($urandom);
      advance(dv, c, v, 1'b0);
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL queueing cyc=%0d got=%b want=%b", cyc, got, want);
      end
      n_busy += int'(busy);
      n_ovr  += int'(overrun);
    end
    checks++;
    if (n_busy != 400 || n_ovr != 1) begin
      errors++;
      $display("FAIL queue_totals got busy=%0d ovr=%0d want busy=400 ovr=1", n_busy, n_ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got, want;
    logic       dv, rst;
    logic [7:0] c;
    for (int i = 0; i < 300; i++) begin
      dv  = (i == 0 || i == 80);
      rst = (i == 50);
      c   = (i == 0) ? RESP_ERROR : RESP_OK;
      advance(dv, c, (i == 80) ? RESP_OK : 8'($urandom), rst);
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (i == 50) begin
        checks++;
        if ({tx, busy} !== 2'b10) begin
          errors++;
          $display("FAIL reset_abort got tx/busy=%b want=10", {tx, busy});
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] got, want;
    logic       fire = 1'b0;
    logic       fired = 1'b0;
    int n_busy = 0;
    advance(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 1; i < 420; i++) begin
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL simultaneous cyc=%0d got=%b want=%b", cyc, got, want);
      end
      n_busy += int'(busy);
      fire = want[1] && !fired;
      if (fire) fired = 1'b1;
      advance(fire, 8'($urandom), 8'($urandom), 1'b0);
    end
    checks++;
    if (n_busy != 400) begin
      errors++;
      $display("FAIL simultaneous_busy got=%0d want=400", n_busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] got, want;
    logic       dv = 1'b0;
    logic       rst;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) dv = ~dv;
      rst = ($urandom_range(0, 1499) == 0);
      advance(dv, 8'($urandom), 8'($urandom), rst);
      got  = {tx, busy, done, overrun};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
    for (int i = 0; i < 450; i++) advance(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    dados_validos    = 1'b0;
    response_command = 8'h00;
    response_value   = 8'h00;
    test_reset();
    test_basic_frame();
    test_held_level();
    test_queueing();
    test_reset_mid_frame();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
